mem_access_unit: RTL

- Initiator side of the data-memory interface: turns load/store requests from the MIPS pipeline into memRead/memWrite/Address/write_data cycles toward DataMemory.
- Data memory is word-addressed. This unit converts byte addresses to word indices and does byte/halfword access: extract plus sign/zero extension for loads, read-modify-write for stores.
- Sits between the EX/MEM stage and DataMemory; stalls the pipeline through busy.

---
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Pipeline/DataMemory signal bundle for mem_access_unit.
// slave = the access unit; master = pipeline plus memory side.
interface mem_access_unit_if;
  logic        req;
  logic        is_store;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        memRead;
  logic        memWrite;
  logic [31:0] Address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport slave (
    input  req, is_store, op, addr, wdata, read_data,
    output busy, done, rdata, misaligned, memRead, memWrite, Address, write_data
  );

  modport master (
    output req, is_store, op, addr, wdata, read_data,
    input  busy, done, rdata, misaligned, memRead, memWrite, Address, write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed, big-endian data memory (byte/half/word, RMW sub-word stores).
// Define MEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses and flag them on misaligned.
module mem_access_unit #(
  parameter int MEM_DEPTH   = 21,
  parameter int WAIT_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for req
  // RD    | memRead held WAIT_CYCLES cycles, read_data sampled on the last edge
  // WR    | single memWrite cycle
  // DONE  | done pulse, then back to IDLE
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        store_q, store_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wsub_q, wsub_d;
  logic [31:0] index_q, index_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wrd_q, wrd_d;
  logic        mis_q, mis_d;

  logic req_sub, req_oor, req_mis;

  function automatic logic is_sub(input logic [2:0] o);
    return (o == 3'd0) || (o == 3'd1) || (o == 3'd4) || (o == 3'd5);
  endfunction

  // Lane extraction and extension; op[0] selects half, op[2] selects zero-extension.
  function automatic logic [31:0] load_word(input logic [2:0] o, input logic [1:0] lane,
                                            input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[31:24];
    case (lane)
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      2'd3:    b = w[7:0];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[15:0] : w[31:16];
    r = w;
    if (is_sub(o)) begin
      if (o[0]) r = {{16{h[15] & ~o[2]}}, h};
      else      r = {{24{b[7] & ~o[2]}}, b};
    end
    return r;
  endfunction

  function automatic logic [31:0] merge_word(input logic [2:0] o, input logic [1:0] lane,
                                             input logic [31:0] w, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (o[0]) begin
      if (lane[1]) r[15:0]  = d;
      else         r[31:16] = d;
    end else begin
      case (lane)
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        2'd3:    r[7:0]   = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end
    return r;
  endfunction

  assign req_sub = is_sub(bus.op);
  assign req_oor = {2'b00, bus.addr[31:2]} >= 32'(MEM_DEPTH);

`ifdef MEM_ALIGN_CHECK_EN
  assign req_mis = req_sub ? (bus.op[0] & bus.addr[0]) : (bus.addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    store_d = store_q;
    op_d    = op_q;
    lane_d  = lane_q;
    wsub_d  = wsub_q;
    index_d = index_q;
    rdata_d = rdata_q;
    wrd_d   = wrd_q;
    mis_d   = mis_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          store_d = bus.is_store;
          op_d    = bus.op;
          lane_d  = bus.addr[1:0];
          wsub_d  = bus.wdata[15:0];
          index_d = {2'b00, bus.addr[31:2]};
          // Out-of-range and misaligned accesses finish without touching memory.
          if (req_oor || req_mis) begin
            state_d = ST_DONE;
            mis_d   = req_mis;
            if (!bus.is_store && req_oor) rdata_d = 32'h0;
          end else if (bus.is_store && !req_sub) begin
            state_d = ST_WR;
            wrd_d   = bus.wdata;
          end else begin
            state_d = ST_RD;
            wait_d  = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_RD: begin
        if (wait_q == 4'd0) begin
          if (store_q) begin
            wrd_d   = merge_word(op_q, lane_q, bus.read_data, wsub_q);
            state_d = ST_WR;
          end else begin
            rdata_d = load_word(op_q, lane_q, bus.read_data);
            state_d = ST_DONE;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_WR:   state_d = ST_DONE;
      default: begin
        state_d = ST_IDLE;
        mis_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= 4'd0;
      store_q <= 1'b0;
      op_q    <= 3'd0;
      lane_q  <= 2'd0;
      wsub_q  <= 16'h0;
      index_q <= 32'h0;
      rdata_q <= 32'h0;
      wrd_q   <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      store_q <= store_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      wsub_q  <= wsub_d;
      index_q <= index_d;
      rdata_q <= rdata_d;
      wrd_q   <= wrd_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.memRead    = (state_q == ST_RD);
  assign bus.memWrite   = (state_q == ST_WR);
  assign bus.Address    = index_q;
  assign bus.write_data = wrd_q;
  assign bus.rdata      = rdata_q;
  assign bus.misaligned = mis_q;

endmodule
